mux_sel_arbiter: RTL and testbench
==================================

// Module: mux_sel_arbiter
// PURPOSE
// - Owns the select line of the shared 2:1 mux (inputs uno/cero, output Q).
// - Arbitrates between two requesters (uno side, cero side) with a req/gnt/done handshake.
// - Drives sel and registers the muxed data with a valid flag.
// - Sits between the game-logic requesters and the shared mux datapath.
// PARAMETERS
// - DATA_W    1  width of in_uno / in_cero / q
// - IDLE_SEL  0  sel value driven while no grant is active (0 or 1)
// - HOLD_MAX  8  max grant length in cycles before forced release (ARB_TIMEOUT_EN only; >=2)
// PORTS
// - clk        in   1       rising-edge clock
// - rst_n      in   1       synchronous reset, active-low
// - req_uno    in   1       uno requester wants the mux
// - req_cero   in   1       cero requester wants the mux
// - done_uno   in   1       1-cycle release pulse from uno owner (ignored unless gnt_uno)
// - done_cero  in   1       1-cycle release pulse from cero owner (ignored unless gnt_cero)
// - in_uno     in   DATA_W  data routed when sel=1
// - in_cero    in   DATA_W  data routed when sel=0
// - gnt_uno    out  1       uno owns the mux
// - gnt_cero   out  1       cero owns the mux
// - sel        out  1       mux select: 1=uno, 0=cero, IDLE_SEL when idle
// - q          out  DATA_W  registered mux output
// - q_valid    out  1       q holds data from a granted source
// - timeout    out  1       1-cycle pulse on forced release (tied 0 without macro)
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): state=IDLE, gnt_*=0, sel=IDLE_SEL, q=0, q_valid=0,
//   timeout=0, last_owner=CERO (uno wins first tie). Reset mid-grant drops the grant next edge.
// - FSM states: IDLE, OWN_UNO, OWN_CERO. gnt_uno=(state==OWN_UNO), gnt_cero=(state==OWN_CERO); never both.
// - IDLE: req_uno only -> OWN_UNO; req_cero only -> OWN_CERO; both -> side != last_owner; none -> stay.
// - Grant latency: req sampled at edge N -> gnt high after edge N (visible cycle N+1).
// - OWN_x release = done_x, or req_x low (abandon). Next state on release:
//   other req high -> OWN_other (direct hand-over, no idle cycle);
//   else req_x still high -> OWN_x again (new request); else -> IDLE.
// - last_owner updates on every entry to OWN_UNO/OWN_CERO.
// - sel is registered with state: 1 in OWN_UNO, 0 in OWN_CERO, IDLE_SEL in IDLE.
// - q <= sel ? in_uno : in_cero every cycle (one cycle after sel); q_valid <= (state != IDLE).
//   Thus q/q_valid lag gnt by one cycle; after release q_valid falls one cycle after gnt.
// - done_x while not owning x: ignored. done and req drop in same cycle: single release.
// - Requesters must hold req until gnt; dropping req before gnt withdraws it (no grant).
// CONFIGURATION
// - ARB_TIMEOUT_EN defined: hold counter cleared on each grant entry, +1 per owned cycle.
//   When counter == HOLD_MAX-1 and the other req is high, release is forced: hand-over
//   to the other side next edge, timeout pulses 1 cycle. With other req low, no
//   forced release (counter saturates).
// - ARB_TIMEOUT_EN undefined: no counter, grants last until done/req drop, timeout=0.
// TESTING
// - Reset: rst_n=0 two cycles -> gnt_uno=gnt_cero=0, sel=IDLE_SEL, q_valid=0, timeout=0.
// - Single request: req_cero=1 at cycle 0, in_cero=1 -> gnt_cero=1 cycle 1, sel=0, q=1/q_valid=1 cycle 2;
//   done_cero pulse cycle 4 -> gnt_cero=0 cycle 5, q_valid=0 cycle 6.
// - Tie after reset: req_uno=req_cero=1 -> gnt_uno first; done_uno -> gnt_cero next cycle,
//   no idle gap; done_cero with req_uno high -> gnt_uno again (round-robin alternation).
// - Abandon/stray done: owner uno drops req_uno without done -> release next edge;
//   done_cero pulsed while uno owns -> ignored, gnt_uno unchanged.
// - Reset mid-grant: rst_n=0 during OWN_UNO -> gnt_uno=0, sel=IDLE_SEL, q_valid=0 next edge;
//   tie after release of reset -> uno granted.
// - ARB_TIMEOUT_EN, HOLD_MAX=8: uno owns, req_cero=1, no done -> after 8 owned cycles
//   gnt_cero=1, timeout pulses once; without req_cero uno keeps grant indefinitely.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: owns the select line of the shared 2:1 mux (uno/cero).
// It arbitrates uno/cero requesters with a req/gnt/done handshake. Ties go
// round-robin, and uno wins the first tie after reset. It registers the muxed
// data together with a valid flag.
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a grant is
// forced over to a waiting requester after HOLD_MAX owned cycles.
module mux_sel_arbiter #(
    parameter int DATA_W   = 1,
    parameter bit IDLE_SEL = 1'b0,
    parameter int HOLD_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_uno,
    input  logic              req_cero,
    input  logic              done_uno,
    input  logic              done_cero,
    input  logic [DATA_W-1:0] in_uno,
    input  logic [DATA_W-1:0] in_cero,
    output logic              gnt_uno,
    output logic              gnt_cero,
    output logic              sel,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              timeout
);

    typedef enum logic [1:0] {IDLE, OWN_UNO, OWN_CERO} state_t;

    state_t state, state_nxt;
    logic   last_uno;      // 1: uno was granted most recently
    logic   enter;         // a grant (new or re-grant) starts at this edge
    logic   force_uno;     // uno's hold limit hit while cero waits
    logic   force_cero;
    logic   timeout_nxt;
    logic   sel_nxt;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);
    logic [CW-1:0] hold_cnt;

    assign force_uno  = (hold_cnt == HOLD_LAST) && req_cero;
    assign force_cero = (hold_cnt == HOLD_LAST) && req_uno;

    // Owned-cycle counter: restarts on every grant entry, then saturates at the limit
    always_ff @(posedge clk) begin
        if (!rst_n)                                    hold_cnt <= '0;
        else if (enter)                                hold_cnt <= '0;
        else if (state != IDLE && hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
    end

    // Pulse timeout only on the edge where a release was forced
    always_ff @(posedge clk) begin
        if (!rst_n) timeout <= 1'b0;
        else        timeout <= timeout_nxt;
    end
`else
    assign force_uno  = 1'b0;
    assign force_cero = 1'b0;
    assign timeout    = 1'b0;
`endif

    // Next-state logic: grant, hand-over, re-grant and idle decisions
    always_comb begin
        state_nxt   = state;
        enter       = 1'b0;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (req_uno && (!req_cero || !last_uno)) begin
                    state_nxt = OWN_UNO;
                    enter     = 1'b1;
                end else if (req_cero) begin
                    state_nxt = OWN_CERO;
                    enter     = 1'b1;
                end
            end
            OWN_UNO: begin
                if (done_uno || !req_uno || force_uno) begin
                    // A forced release is reported only when nothing else ended the grant
                    timeout_nxt = force_uno && req_uno && !done_uno;
                    if (req_cero) begin
                        state_nxt = OWN_CERO;
                        enter     = 1'b1;
                    end else if (req_uno) begin
                        state_nxt = OWN_UNO;
                        enter     = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            OWN_CERO: begin
                if (done_cero || !req_cero || force_cero) begin
                    timeout_nxt = force_cero && req_cero && !done_cero;
                    if (req_uno) begin
                        state_nxt = OWN_UNO;
                        enter     = 1'b1;
                    end else if (req_cero) begin
                        state_nxt = OWN_CERO;
                        enter     = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Select follows the next state so that sel is registered with the state
    always_comb begin
        sel_nxt = IDLE_SEL;
        if (state_nxt == OWN_UNO)       sel_nxt = 1'b1;
        else if (state_nxt == OWN_CERO) sel_nxt = 1'b0;
    end

    // State, round-robin history and select registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_uno <= 1'b0;
            sel      <= IDLE_SEL;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            if (enter) last_uno <= (state_nxt == OWN_UNO);
        end
    end

    // Registered mux output: one cycle behind sel, valid while a grant was held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q       <= sel ? in_uno : in_cero;
            q_valid <= (state != IDLE);
        end
    end

    assign gnt_uno  = (state == OWN_UNO);
    assign gnt_cero = (state == OWN_CERO);

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench for mux_sel_arbiter. Each directed step pushes the
// hand-computed outputs expected after the next clock edge. A monitor pops
// and compares them just after that edge. The timeout expectations follow
// ARB_TIMEOUT_EN.
module tb_mux_sel_arbiter;

    localparam int DW = 4;
    localparam logic [DW-1:0] A = 4'hA;   // in_uno
    localparam logic [DW-1:0] F = 4'h5;   // in_cero

    logic          clk = 1'b0;
    logic          rst_n, req_uno, req_cero, done_uno, done_cero;
    logic [DW-1:0] in_uno, in_cero;
    logic          gnt_uno, gnt_cero, sel, q_valid, timeout;
    logic [DW-1:0] q;

    typedef struct packed {
        logic          gu;
        logic          gc;
        logic          sel;
        logic          qv;
        logic [DW-1:0] q;
        logic          to;
    } exp_t;

    exp_t sb[$];
    int   sb_id[$];
    int   step_no  = 0;
    int   checks   = 0;
    int   failures = 0;

    mux_sel_arbiter #(.DATA_W(DW), .IDLE_SEL(1'b0), .HOLD_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_uno(req_uno), .req_cero(req_cero),
        .done_uno(done_uno), .done_cero(done_cero),
        .in_uno(in_uno), .in_cero(in_cero),
        .gnt_uno(gnt_uno), .gnt_cero(gnt_cero), .sel(sel),
        .q(q), .q_valid(q_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic step(input logic r, ru, rc, du, dc,
                        input logic gu, gc, s, qv, input logic [DW-1:0] qq, input logic to);
        exp_t e;
        @(negedge clk);
        rst_n = r; req_uno = ru; req_cero = rc; done_uno = du; done_cero = dc;
        e = '{gu: gu, gc: gc, sel: s, qv: qv, q: qq, to: to};
        sb.push_back(e);
        sb_id.push_back(step_no);
        step_no++;
    endtask

    // Monitor: compare the DUT against the oldest expectation just after each edge
    always @(posedge clk) begin
        exp_t e, got;
        int   id;
        #1;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            id  = sb_id.pop_front();
            got = '{gu: gnt_uno, gc: gnt_cero, sel: sel, qv: q_valid, q: q, to: timeout};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL step%0d gu/gc/sel/qv/q/to got=%b/%b/%b/%b/%h/%b exp=%b/%b/%b/%b/%h/%b",
                         id, got.gu, got.gc, got.sel, got.qv, got.q, got.to,
                         e.gu, e.gc, e.sel, e.qv, e.q, e.to);
            end
        end
    end

    initial begin
        rst_n = 1'b0; req_uno = 0; req_cero = 0; done_uno = 0; done_cero = 0;
        in_uno = A; in_cero = F;

        // reset held two cycles
        step(0,0,0,0,0, 0,0,0,0,4'h0,0);
        step(0,0,0,0,0, 0,0,0,0,4'h0,0);
        step(1,0,0,0,0, 0,0,0,0,F,0);
        // single cero request, done with req drop
        step(1,0,1,0,0, 0,1,0,0,F,0);
        step(1,0,1,0,0, 0,1,0,1,F,0);
        step(1,0,1,0,0, 0,1,0,1,F,0);
        step(1,0,0,0,1, 0,0,0,1,F,0);
        step(1,0,0,0,0, 0,0,0,0,F,0);
        // tie -> uno, done -> direct hand-over to cero, then back to uno
        step(1,1,1,0,0, 1,0,1,0,F,0);
        step(1,1,1,0,0, 1,0,1,1,A,0);
        step(1,1,1,1,0, 0,1,0,1,A,0);
        step(1,1,1,0,0, 0,1,0,1,F,0);
        step(1,1,0,0,1, 1,0,1,1,F,0);
        step(1,1,0,0,0, 1,0,1,1,A,0);
        // stray done_cero ignored, then uno abandons
        step(1,1,0,0,1, 1,0,1,1,A,0);
        step(1,0,0,0,0, 0,0,0,1,A,0);
        step(1,0,0,0,0, 0,0,0,0,F,0);
        // done with req still high and no competitor -> re-grant, no gap
        step(1,1,0,0,0, 1,0,1,0,F,0);
        step(1,1,0,1,0, 1,0,1,1,A,0);
        step(1,1,0,0,0, 1,0,1,1,A,0);
        // reset mid-grant, then a tie goes to uno
        step(0,1,0,0,0, 0,0,0,0,4'h0,0);
        step(1,1,1,0,0, 1,0,1,0,F,0);
        step(1,0,1,0,0, 0,1,0,1,A,0);
        step(1,0,0,0,0, 0,0,0,1,F,0);
        step(1,0,0,0,0, 0,0,0,0,F,0);
        // uno owns while cero waits
        step(1,1,0,0,0, 1,0,1,0,F,0);
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 7; k++) step(1,1,1,0,0, 1,0,1,1,A,0);
        step(1,1,1,0,0, 0,1,0,1,A,1);
        step(1,1,1,0,0, 0,1,0,1,F,0);
        step(1,0,0,0,0, 0,0,0,1,F,0);
`else
        for (int k = 0; k < 9; k++) step(1,1,1,0,0, 1,0,1,1,A,0);
        step(1,0,0,0,0, 0,0,0,1,A,0);
`endif
        step(1,0,0,0,0, 0,0,0,0,F,0);
        // long uncontested grant, then cero arrives late
        step(1,1,0,0,0, 1,0,1,0,F,0);
        for (int k = 0; k < 12; k++) step(1,1,0,0,0, 1,0,1,1,A,0);
`ifdef ARB_TIMEOUT_EN
        step(1,1,1,0,0, 0,1,0,1,A,1);
        step(1,0,0,0,0, 0,0,0,1,F,0);
`else
        step(1,1,1,0,0, 1,0,1,1,A,0);
        step(1,0,0,0,0, 0,0,0,1,A,0);
`endif
        step(1,0,0,0,0, 0,0,0,0,F,0);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
